// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants for the prefetching IF stage.
package rv_fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_INSTR_WIDTH = 32;
    localparam int unsigned PC_STEP         = 4;

    typedef struct packed {
        logic [DEF_INSTR_WIDTH-1:0] instr;
        logic [DEF_ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; push to a full / pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  T                           pushData,
    input  logic                       pop,
    output T                           popData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    T                mem [DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] cnt;
    logic            doPush;
    logic            doPop;

    always_comb begin
        full    = (cnt == CntW'(DEPTH));
        empty   = (cnt == '0);
        doPush  = push && !full;
        doPop   = pop && !empty;
        popData = mem[rdPtr];
        count   = cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PtrW'(1);
            if (doPop)  rdPtr <= rdPtr + PtrW'(1);
            cnt <= cnt + CntW'(doPush) - CntW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage: credit-based prefetch into a queue, in-order responses,
// redirect flushes the queue and discards responses to requests issued before it.
module if_prefetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned           INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_vld,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_next_pc
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } queueEntryT;

    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [CntW-1:0]       outstanding;
    logic [CntW-1:0]       dropCnt;
    logic [CntW-1:0]       occupancy;

    // PCs of issued requests, consumed by every response (kept or dropped).
    logic [ADDR_WIDTH-1:0] pcFifo [DEPTH];
    logic [PtrW-1:0]       pcWrPtr;
    logic [PtrW-1:0]       pcRdPtr;

    logic       reqFire;
    logic       respKeep;
    logic       popFire;
    logic       qFull;
    logic       qEmpty;
    queueEntryT pushEntry;
    queueEntryT headEntry;

    always_comb begin
        imem_req  = !rst && !redirect_vld && !qFull
                    && (({1'b0, occupancy} + {1'b0, outstanding}) < (CntW + 1)'(DEPTH));
        imem_addr = fetchPc;
        reqFire   = imem_req && imem_gnt;
        respKeep  = imem_rvalid && (dropCnt == '0) && !redirect_vld;
        popFire   = !qEmpty && id_ready && !redirect_vld;
        pushEntry = '{instr: imem_rdata, pc: pcFifo[pcRdPtr]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
            pcWrPtr     <= '0;
            pcRdPtr     <= '0;
        end else begin
            if (redirect_vld) begin
                fetchPc <= redirect_pc & ~ADDR_WIDTH'(3);
            end else if (reqFire) begin
                fetchPc <= fetchPc + ADDR_WIDTH'(PC_STEP);
            end
            outstanding <= outstanding + CntW'(reqFire) - CntW'(imem_rvalid);
            // Everything still in flight after this cycle's response is stale.
            if (redirect_vld) begin
                dropCnt <= outstanding - CntW'(imem_rvalid);
            end else if (imem_rvalid && (dropCnt != '0)) begin
                dropCnt <= dropCnt - CntW'(1);
            end
            if (reqFire)     pcWrPtr <= pcWrPtr + PtrW'(1);
            if (imem_rvalid) pcRdPtr <= pcRdPtr + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) pcFifo[pcWrPtr] <= fetchPc;
    end

    sync_fifo #(
        .T     (queueEntryT),
        .DEPTH (DEPTH)
    ) entryQueue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_vld),
        .push     (respKeep),
        .pushData (pushEntry),
        .pop      (popFire),
        .popData  (headEntry),
        .full     (qFull),
        .empty    (qEmpty),
        .count    (occupancy)
    );

    always_comb begin
        id_valid   = !qEmpty;
        id_instr   = qEmpty ? '0 : headEntry.instr;
        id_pc      = qEmpty ? '0 : headEntry.pc;
        id_next_pc = qEmpty ? '0 : headEntry.pc + ADDR_WIDTH'(PC_STEP);
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue against an epoch-tagged memory and delivery-queue model.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_next_pc;

    if_prefetch_queue #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (DEPTH),
        .RESET_PC    (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_next_pc   (id_next_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          epoch;
        int          due;
    } reqT;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          latMin = 1;
    int          latMax = 1;
    int          dutGrants = 0;
    logic [31:0] fetchPc = '0;
    reqT         pend[$];
    logic [31:0] modelQ[$];
    logic [31:0] dutSeen[$];
    logic        sampValid;
    logic [31:0] sampPc;
    logic [31:0] sampNextPc;
    logic [31:0] sampAddr;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b1;
        redirect_vld = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        id_ready = 1'b0;
        repeat (n) @(negedge clk);
        checkEq("rst_id_valid", id_valid, 0);
        checkEq("rst_imem_req", imem_req, 0);
        checkEq("rst_id_pc", id_pc, 0);
        checkEq("rst_id_instr", id_instr, 0);
        checkEq("rst_id_next_pc", id_next_pc, 0);
        rst = 1'b0;
        pend.delete();
        modelQ.delete();
        fetchPc = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy,
                        input int gntPct);
        logic gntV;
        logic rv;
        logic expValid;
        logic expReq;
        reqT  r;
        @(negedge clk);
        gntV = ($urandom_range(0, 99) < gntPct);
        rv   = (pend.size() != 0) && (pend[0].due <= cyc);
        redirect_vld = redir;
        redirect_pc  = tgt;
        id_ready     = rdy;
        imem_gnt     = gntV;
        imem_rvalid  = rv;
        imem_rdata   = rv ? instrOf(pend[0].pc) : $urandom;
        #1;
        expValid = (modelQ.size() != 0);
        expReq   = !redir && ((modelQ.size() + pend.size()) < DEPTH);
        checkEq("id_valid", id_valid, expValid);
        if (expValid) begin
            checkEq("id_pc", id_pc, modelQ[0]);
            checkEq("id_instr", id_instr, instrOf(modelQ[0]));
            checkEq("id_next_pc", id_next_pc, modelQ[0] + 32'd4);
        end
        checkEq("imem_req", imem_req, expReq);
        checkEq("imem_addr", imem_addr, fetchPc);
        if (dut.entryQueue.push) checkEq("push_to_full", dut.entryQueue.full, 0);
        sampValid  = id_valid;
        sampPc     = id_pc;
        sampNextPc = id_next_pc;
        sampAddr   = imem_addr;
        if (id_valid && rdy && !redir) dutSeen.push_back(id_pc);
        if (imem_req && gntV) dutGrants++;

        if (expValid && rdy && !redir) void'(modelQ.pop_front());
        if (rv) begin
            r = pend.pop_front();
            if (!redir && r.epoch == epoch) modelQ.push_back(r.pc);
        end
        if (expReq && gntV) begin
            pend.push_back('{pc: fetchPc, epoch: epoch, due: cyc + $urandom_range(latMin, latMax)});
            fetchPc = fetchPc + 32'd4;
        end
        if (redir) begin
            epoch++;
            modelQ.delete();
            fetchPc = tgt & ~32'h3;
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  waited;
        int  breaks;
        logic found;

        // Streaming from a zero-wait memory: one instruction per cycle after the fill.
        doReset(2);
        dutSeen.delete();
        repeat (20) step(1'b0, '0, 1'b1, 100);
        checkEq("s1_count", dutSeen.size(), 18);
        for (int i = 0; i < 4; i++) begin
            checkEq("s1_pc", (dutSeen.size() > i) ? dutSeen[i] : 32'hdead_beef, 32'(i * 4));
        end

        // Decode stalled: credit stops requests at DEPTH, then drain and resume.
        doReset(1);
        dutGrants = 0;
        repeat (10) step(1'b0, '0, 1'b0, 100);
        checkEq("s2_grants", dutGrants, DEPTH);
        checkEq("s2_req_low", imem_req, 0);
        checkEq("s2_head_held", sampPc, 0);
        dutSeen.delete();
        repeat (10) step(1'b0, '0, 1'b1, 100);
        for (int i = 0; i < 5; i++) begin
            checkEq("s2_drain_pc", (dutSeen.size() > i) ? dutSeen[i] : 32'hdead_beef,
                    32'(i * 4));
        end

        // Fixed 3-cycle latency with random grant stalls and random decode stalls.
        doReset(1);
        latMin = 3;
        latMax = 3;
        dutSeen.delete();
        repeat (200) step(1'b0, '0, ($urandom_range(0, 3) != 0), 50);
        breaks = 0;
        for (int i = 1; i < dutSeen.size(); i++) begin
            if (dutSeen[i] != dutSeen[i-1] + 32'd4) breaks++;
        end
        checkEq("s3_order_breaks", breaks, 0);
        checkEq("s3_progress", (dutSeen.size() > 20), 1);

        // Redirect with three in flight, the oldest returning in the redirect cycle.
        doReset(1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 3 && pend[0].due <= cyc) found = 1'b1;
            else step(1'b0, '0, 1'b1, 100);
        end
        checkEq("s4_setup", found, 1);
        step(1'b1, 32'h100, 1'b1, 100);
        waited = 0;
        found = 1'b0;
        while (!found && waited < 30) begin
            step(1'b0, '0, 1'b1, 100);
            waited++;
            found = sampValid;
        end
        checkEq("s4_valid_seen", found, 1);
        checkEq("s4_first_pc", sampPc, 32'h100);
        checkEq("s4_bubble", (waited >= 3), 1);

        // Unaligned redirect then a second redirect one cycle later.
        step(1'b1, 32'h202, 1'b1, 100);
        step(1'b1, 32'h300, 1'b1, 100);
        checkEq("s5_aligned_addr", sampAddr, 32'h200);
        waited = 0;
        found = 1'b0;
        while (!found && waited < 30) begin
            step(1'b0, '0, 1'b1, 100);
            waited++;
            found = sampValid;
        end
        checkEq("s5_valid_seen", found, 1);
        checkEq("s5_first_pc", sampPc, 32'h300);
        repeat (10) step(1'b0, '0, 1'b1, 100);

        // PC wrap-around at the top of the address space.
        latMin = 1;
        latMax = 1;
        step(1'b1, 32'hffff_fffc, 1'b1, 100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b1, 100);
            found = sampValid && (sampPc == 32'hffff_fffc);
        end
        checkEq("s6_top_seen", found, 1);
        checkEq("s6_next_pc_wrap", sampNextPc, 32'h0);
        step(1'b0, '0, 1'b1, 100);
        checkEq("s6_wrap_pc", sampPc, 32'h0);

        // Reset with a full queue.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b0, 100);
            found = (modelQ.size() == DEPTH);
        end
        checkEq("s6_full", found, 1);
        doReset(1);
        waited = 0;
        found = 1'b0;
        while (!found && waited < 20) begin
            step(1'b0, '0, 1'b1, 100);
            waited++;
            found = sampValid;
        end
        checkEq("s6_restart_seen", found, 1);
        checkEq("s6_restart_pc", sampPc, 32'h0);

        // Random traffic with occasional redirects.
        latMin = 1;
        latMax = 4;
        repeat (400) begin
            if ($urandom_range(0, 99) < 3) step(1'b1, $urandom, $urandom_range(0, 1), 60);
            else step(1'b0, '0, ($urandom_range(0, 9) < 6), 60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
